// File: rtl/a0_uart_tx.sv
// Watches the CPU a0 register, queues each new value and streams it out LSB byte first on a UART line.
// Define A0_UART_PARITY_EN to insert an even-parity bit into every byte frame.
module a0_uart_tx #(
   parameter int DATA_WIDTH   = 32,
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         a0,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    overflow_cnt
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int CW     = $clog2(CLKS_PER_BIT);
   localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);
   localparam logic [PW:0]   FULL_LVL  = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef A0_UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t                 state, state_nx;
   logic [DATA_WIDTH-1:0]  prev_a0, shreg, sh_nx;
   logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [PW-1:0]          rptr, wptr;
   logic [PW:0]            level;
   logic [CW-1:0]          baud, baud_nx;
   logic [2:0]             bit_cnt, bit_nx;
   logic [BW-1:0]          byte_idx, byte_nx;
   logic                   tx_nx, pop, push, full, wr, baud_end;
`ifdef A0_UART_PARITY_EN
   logic                   par, par_nx;
`endif

   assign push     = (a0 != prev_a0);
   assign full     = (level == FULL_LVL);
   assign wr       = push && (!full || pop);
   assign baud_end = (baud == BAUD_LAST);

   // FIFO bookkeeping; a full FIFO still accepts when the head leaves on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_a0      <= '0;
         rptr         <= '0;
         wptr         <= '0;
         level        <= '0;
         overflow_cnt <= '0;
      end else begin
         prev_a0 <= a0;
         if (wr)  wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         case ({wr, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (push && full && !pop && overflow_cnt != 8'hFF)
            overflow_cnt <= overflow_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= a0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         baud     <= '0;
         bit_cnt  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
`ifdef A0_UART_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         tx       <= tx_nx;
         baud     <= baud_nx;
         bit_cnt  <= bit_nx;
         byte_idx <= byte_nx;
         shreg    <= sh_nx;
`ifdef A0_UART_PARITY_EN
         par      <= par_nx;
`endif
      end
   end

   // tx_nx is the level for the next bit period, so tx itself stays a plain register
   always_comb begin
      state_nx = state;
      tx_nx    = tx;
      baud_nx  = baud;
      bit_nx   = bit_cnt;
      byte_nx  = byte_idx;
      sh_nx    = shreg;
      pop      = 1'b0;
`ifdef A0_UART_PARITY_EN
      par_nx   = par;
`endif
      if (state != S_IDLE) baud_nx = baud_end ? '0 : baud + 1'b1;
      case (state)
         S_IDLE: if (level != '0) begin
            pop      = 1'b1;
            sh_nx    = mem[rptr];
            byte_nx  = '0;
            baud_nx  = '0;
            tx_nx    = 1'b0;
            state_nx = S_START;
         end
         S_START: if (baud_end) begin
            tx_nx    = shreg[0];
            bit_nx   = '0;
`ifdef A0_UART_PARITY_EN
            par_nx   = 1'b0;
`endif
            state_nx = S_DATA;
         end
         // the shift register walks through the whole word, so the next byte lands in [7:0]
         S_DATA: if (baud_end) begin
            sh_nx = shreg >> 1;
`ifdef A0_UART_PARITY_EN
            par_nx = par ^ shreg[0];
`endif
            if (bit_cnt == 3'd7) begin
`ifdef A0_UART_PARITY_EN
               tx_nx    = par ^ shreg[0];
               state_nx = S_PARITY;
`else
               tx_nx    = 1'b1;
               state_nx = S_STOP;
`endif
            end else begin
               bit_nx = bit_cnt + 1'b1;
               tx_nx  = shreg[1];
            end
         end
`ifdef A0_UART_PARITY_EN
         S_PARITY: if (baud_end) begin
            tx_nx    = 1'b1;
            state_nx = S_STOP;
         end
`endif
         S_STOP: if (baud_end) begin
            if (byte_idx != BYTE_LAST) begin
               byte_nx  = byte_idx + 1'b1;
               tx_nx    = 1'b0;
               state_nx = S_START;
            end else begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy       = (state != S_IDLE);
   assign fifo_level = level;

endmodule

// File: doc/a0_uart_tx.md
# a0_uart_tx

Downstream consumer of the CPU's `a0` result register: watches `a0` every cycle, queues each new value in a small FIFO, and serialises queued words onto a single UART transmit line, least-significant byte first. It sits directly after the `cpu` top in the test/board wrapper, so program results stream off-chip without a simulator probe. It owns all buffering and baud timing, and it drops and counts values when the FIFO is full.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of `a0`. Must be a multiple of 8. The word is `DATA_WIDTH/8` bytes.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit. Must be ≥ 2.
- `FIFO_DEPTH`, 4: number of queued words. Must be a power of two and ≥ 2.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `a0`  in  DATA_WIDTH: CPU result register value.
- `tx`  out  1: UART line; idle high.
- `busy`  out  1: high whenever the transmitter state is not IDLE.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: words currently queued.
- `overflow_cnt`  out  8: count of dropped values; saturates at 255.

## Operation
- Change detect: register `prev_a0`, reset value 0. On every edge, if `a0 != prev_a0`, a push is requested. `prev_a0 <= a0` updates on every edge, including edges where the push is dropped.
- FIFO: circular buffer with a read pointer, a write pointer and a level count.
  - A push with level < FIFO_DEPTH writes the word.
  - A push when full, with no pop on the same edge, is dropped and increments `overflow_cnt`, saturating at 255.
  - A push and a pop on the same edge when full: both happen, and the level is unchanged.
  - There is no bypass. A word pushed into an empty FIFO is popped no earlier than the next edge.
- Transmitter FSM states: IDLE, START, DATA, PARITY (only when `A0_UART_PARITY_EN` is defined), STOP. It keeps a bit counter (0–7), a byte index (0 to DATA_WIDTH/8−1) and a baud counter (0 to CLKS_PER_BIT−1).
  - IDLE: when level ≠ 0, pop the head word into the shift register, clear byte index and baud counter, drive `tx<=0`, and go to START.
  - START, DATA, PARITY and STOP each hold `tx` for CLKS_PER_BIT cycles.
  - DATA sends byte bits LSB first over 8 bit periods.
  - STOP drives `tx=1`. At the end of STOP:
    - If the byte index is below the last byte, increment it, drive `tx<=0`, and go to START. There is no gap between bytes.
    - Otherwise go to IDLE.
- `tx` is registered; there is no combinational path from state to `tx`.

## Timing
- Reset values: `tx=1`, `busy=0`, `fifo_level=0`, `overflow_cnt=0`. Reset also clears the FSM to IDLE, empties the FIFO and sets `prev_a0=0`.
- Reset mid-frame: `tx` returns high asynchronously. The partial frame is abandoned, not completed.
- Push latency: `a0` changes before edge N, so the value is pushed at edge N. At the earliest it is popped at edge N+1, and `tx` falls at N+1.
- Frame length: 10 bit periods per byte, or 11 with parity.
- Word length: (DATA_WIDTH/8)·10·CLKS_PER_BIT cycles with `busy=1`.
- Back-to-back words: exactly one IDLE cycle, with `tx=1`, between the last stop bit of one word and the next start bit.
- After reset is released with `a0≠0`, the first edge pushes `a0`, because `prev_a0` was cleared.

## Configuration
- `A0_UART_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. It carries the even-parity bit, which is the XOR of the 8 data bits. Frames are 11 bits.
- `A0_UART_PARITY_EN` undefined: no PARITY state exists, and frames are 8N1 (10 bits).

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset check: hold `rst` high, then release with `a0=0` held for 200 cycles → `tx=1`, `busy=0`, `fifo_level=0`, `overflow_cnt=0` throughout. No frame is sent.
- Single word: change `a0` from 0 to 0x000000A5 → bytes A5, 00, 00, 00 are sent. The first data bits are 1,0,1,0,0,1,0,1, each held 4 cycles. `busy` is high for 160 cycles.
- Overflow: change `a0` on 7 consecutive edges to 1..7 → words 1–5 are transmitted in order, 6 and 7 are dropped, `overflow_cnt=2`, and `fifo_level` peaks at 4.
- Parity (macro defined): `a0`=0x00000007 → byte 0 frame is start, 1,1,1,0,0,0,0,0, parity 1, stop. Frame length is 44 cycles. With the macro undefined the frame length is 40 cycles.
- Reset mid-frame: assert `rst` during byte 1's data bits → `tx=1` immediately, `fifo_level=0`, `busy=0`. Release with `a0` unchanged and non-zero → the word is re-pushed and retransmitted from byte 0.
- Saturation: cause 300 drops → `overflow_cnt` holds at 255 with no wrap.
